// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_if
// Description : Event inputs and sequencing outputs of the game flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_pause;
    logic       player_hit;
    logic       wave_cleared;
    logic       invaders_landed;
    logic       score_done;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_rst;
    logic       wave_rst;
    logic       respawn;
    logic       run;
    logic       show_title;
    logic       show_over;
    logic [3:0] wave;

    modport slave (
        input  frame_tick, btn_start, btn_pause, player_hit, wave_cleared,
               invaders_landed, score_done, lives,
        output state, game_rst, wave_rst, respawn, run, show_title, show_over, wave
    );

    modport master (
        output frame_tick, btn_start, btn_pause, player_hit, wave_cleared,
               invaders_landed, score_done, lives,
        input  state, game_rst, wave_rst, respawn, run, show_title, show_over, wave
    );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Game phase sequencer with frame-timed hit/clear/over phases.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int RESPAWN_FRAMES = 60,
    parameter int CLEAR_FRAMES   = 90,
    parameter int OVER_FRAMES    = 180,
    parameter int MAX_WAVE       = 15
) (
    input  wire logic        clk,
    input  wire logic        arst,
    game_flow_ctrl_if.slave  bus
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_PLAY  = 3'd2;
    localparam logic [2:0] c_PAUSE = 3'd3;
    localparam logic [2:0] c_HIT   = 3'd4;
    localparam logic [2:0] c_CLEAR = 3'd5;
    localparam logic [2:0] c_OVER  = 3'd6;

    localparam logic [7:0] c_RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] c_CLEAR_LAST   = 8'(CLEAR_FRAMES - 1);
    localparam logic [7:0] c_OVER_LAST    = 8'(OVER_FRAMES - 1);
    localparam logic [3:0] c_MAX_WAVE     = 4'(MAX_WAVE);

    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] wave_q, wave_d;
    logic       game_rst_q, game_rst_d;
    logic       wave_rst_q, wave_rst_d;
    logic       respawn_q, respawn_d;
    logic       run_q, run_d;
    logic       show_title_q, show_title_d;
    logic       show_over_q, show_over_d;

    // Expiry fires on the Nth tick: count already at N-1 and a tick arriving now.
    logic w_respawn_done, w_clear_done, w_over_done;
    assign w_respawn_done = bus.frame_tick && (timer_q == c_RESPAWN_LAST);
    assign w_clear_done   = bus.frame_tick && (timer_q == c_CLEAR_LAST);
    assign w_over_done    = bus.frame_tick && (timer_q == c_OVER_LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= c_IDLE;
            timer_q      <= 8'd0;
            wave_q       <= 4'd0;
            game_rst_q   <= 1'b0;
            wave_rst_q   <= 1'b0;
            respawn_q    <= 1'b0;
            run_q        <= 1'b0;
            show_title_q <= 1'b1;
            show_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            wave_q       <= wave_d;
            game_rst_q   <= game_rst_d;
            wave_rst_q   <= wave_rst_d;
            respawn_q    <= respawn_d;
            run_q        <= run_d;
            show_title_q <= show_title_d;
            show_over_q  <= show_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (bus.btn_start) state_d = c_START;
            c_START: state_d = c_PLAY;
            c_PLAY: begin
                if (bus.invaders_landed || bus.score_done) state_d = c_OVER;
                else if (bus.player_hit)                   state_d = c_HIT;
                else if (bus.wave_cleared)                 state_d = c_CLEAR;
                else if (bus.btn_pause)                    state_d = c_PAUSE;
            end
            c_PAUSE: if (bus.btn_pause) state_d = c_PLAY;
            c_HIT: begin
                if (bus.score_done)  state_d = c_OVER;
                else if (w_respawn_done) state_d = (bus.lives == 2'd0) ? c_OVER : c_PLAY;
            end
            c_CLEAR: if (w_clear_done) state_d = c_PLAY;
            c_OVER: begin
                if (bus.btn_start)   state_d = c_START;
                else if (w_over_done) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs are derived from the transition so they appear with the new state.
    always_comb begin
        timer_d      = timer_q;
        wave_d       = wave_q;
        game_rst_d   = 1'b0;
        wave_rst_d   = 1'b0;
        respawn_d    = 1'b0;
        run_d        = (state_d == c_PLAY);
        show_title_d = (state_d == c_IDLE);
        show_over_d  = (state_d == c_OVER);

        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if (bus.frame_tick &&
                     (state_q == c_HIT || state_q == c_CLEAR || state_q == c_OVER)) begin
            timer_d = timer_q + 8'd1;
        end

        if (state_d == c_START && state_q != c_START) begin
            game_rst_d = 1'b1;
            wave_rst_d = 1'b1;
            wave_d     = 4'd1;
        end

        if (state_q == c_CLEAR && state_d == c_PLAY) begin
            wave_rst_d = 1'b1;
            wave_d     = (wave_q >= c_MAX_WAVE) ? c_MAX_WAVE : wave_q + 4'd1;
        end

        if (state_q == c_HIT && state_d == c_PLAY) respawn_d = 1'b1;
    end

    assign bus.state      = state_q;
    assign bus.wave       = wave_q;
    assign bus.game_rst   = game_rst_q;
    assign bus.wave_rst   = wave_rst_q;
    assign bus.respawn    = respawn_q;
    assign bus.run        = run_q;
    assign bus.show_title = show_title_q;
    assign bus.show_over  = show_over_q;
endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_ctrl
// Description : Self-checking scoreboard bench for game_flow_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;
    logic clk;
    logic arst;
    int   n_chk;
    int   n_pass;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .RESPAWN_FRAMES (3),
        .CLEAR_FRAMES   (1),
        .OVER_FRAMES    (4),
        .MAX_WAVE       (2)
    ) u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    exp_t exp_q[$];

    // {state, game_rst, wave_rst, respawn, run, show_title, show_over, wave}
    function automatic logic [12:0] ev(input int s, input bit gr, input bit wr,
                                       input bit rs, input int w);
        logic run_e, title_e, over_e;
        run_e   = (s == 2);
        title_e = (s == 0);
        over_e  = (s == 6);
        return {3'(s), gr, wr, rs, run_e, title_e, over_e, 4'(w)};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.state, bus.game_rst, bus.wave_rst, bus.respawn, bus.run,
                bus.show_title, bus.show_over, bus.wave};
    endfunction

    task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic compare_next();
        exp_t e;
        e = exp_q.pop_front();
        check_eq(e.tag, observed(), e.val);
    endtask

    // Drives one cycle of inputs, records the expectation, then compares after the edge.
    task automatic step(input string tag, input bit st, input bit pa, input bit hit,
                        input bit wc, input bit land, input bit sd, input bit ft,
                        input logic [12:0] e);
        bus.btn_start       = st;
        bus.btn_pause       = pa;
        bus.player_hit      = hit;
        bus.wave_cleared    = wc;
        bus.invaders_landed = land;
        bus.score_done      = sd;
        bus.frame_tick      = ft;
        exp_q.push_back('{tag, e});
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        arst   = 1'b1;
        bus.btn_start = 0; bus.btn_pause = 0; bus.player_hit = 0;
        bus.wave_cleared = 0; bus.invaders_landed = 0; bus.score_done = 0;
        bus.frame_tick = 0; bus.lives = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('{"reset", ev(0, 0, 0, 0, 0)});
        compare_next();
        arst = 1'b0;

        // tag          st pa hi wc ld sd ft
        step("idle",     0, 0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));
        step("start",    1, 0, 0, 0, 0, 0, 0, ev(1, 1, 1, 0, 1));
        step("play1",    0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));
        step("play2",    0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));

        step("hit",      0, 0, 1, 0, 0, 0, 0, ev(4, 0, 0, 0, 1));
        step("hit_t1",   0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("hit_idle", 0, 0, 0, 0, 0, 0, 0, ev(4, 0, 0, 0, 1));
        step("hit_t2",   0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("respawn",  0, 0, 0, 0, 0, 0, 1, ev(2, 0, 0, 1, 1));
        step("resp_end", 0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));

        bus.lives = 2'd0;
        step("hit_l0",   0, 0, 1, 0, 0, 0, 0, ev(4, 0, 0, 0, 1));
        step("hl0_t1",   0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("hl0_t2",   0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("hl0_over", 0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("over_t1",  0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("over_t2",  0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("replay",   1, 0, 0, 0, 0, 0, 0, ev(1, 1, 1, 0, 1));
        step("rp_play",  0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));

        bus.lives = 2'd2;
        step("prio_hit", 0, 1, 1, 1, 0, 0, 0, ev(4, 0, 0, 0, 1));
        step("pr_t1",    0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("pr_t2",    0, 0, 0, 0, 0, 0, 1, ev(4, 0, 0, 0, 1));
        step("pr_resp",  0, 0, 0, 0, 0, 0, 1, ev(2, 0, 0, 1, 1));
        step("prio_land",0, 0, 1, 0, 1, 0, 0, ev(6, 0, 0, 0, 1));
        step("ov_t1",    0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("ov_t2",    0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("ov_t3",    0, 0, 0, 0, 0, 0, 1, ev(6, 0, 0, 0, 1));
        step("ov_title", 0, 0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 1));

        step("w_start",  1, 0, 0, 0, 0, 0, 0, ev(1, 1, 1, 0, 1));
        step("w_play",   0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));
        step("clr1",     0, 0, 0, 1, 0, 0, 1, ev(5, 0, 0, 0, 1));
        step("clr1_x",   0, 0, 0, 0, 0, 0, 1, ev(2, 0, 1, 0, 2));
        step("clr2",     0, 0, 0, 1, 0, 0, 0, ev(5, 0, 0, 0, 2));
        step("clr2_x",   0, 0, 0, 0, 0, 0, 1, ev(2, 0, 1, 0, 2));
        step("clr3",     0, 0, 0, 1, 0, 0, 0, ev(5, 0, 0, 0, 2));
        step("clr3_hold",0, 0, 0, 0, 0, 0, 0, ev(5, 0, 0, 0, 2));
        step("clr3_x",   0, 0, 0, 0, 0, 0, 1, ev(2, 0, 1, 0, 2));

        step("pause",    0, 1, 0, 0, 0, 0, 0, ev(3, 0, 0, 0, 2));
        step("pause_ign",1, 0, 0, 0, 0, 1, 1, ev(3, 0, 0, 0, 2));
        step("unpause",  0, 1, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 2));
        step("sd_over",  0, 0, 0, 0, 0, 1, 0, ev(6, 0, 0, 0, 2));

        step("a_start",  1, 0, 0, 0, 0, 0, 0, ev(1, 1, 1, 0, 1));
        step("a_play",   0, 0, 0, 0, 0, 0, 0, ev(2, 0, 0, 0, 1));
        step("a_clear",  0, 0, 0, 1, 0, 0, 0, ev(5, 0, 0, 0, 1));
        arst = 1'b1;
        #2;
        exp_q.push_back('{"arst_clear", ev(0, 0, 0, 0, 0)});
        compare_next();
        arst = 1'b0;
        step("post_arst",0, 0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
